// File: rtl/ifid_stage.sv
// ---------------------------------------------------------------------------
// ifid_stage -- instruction-fetch to decode stage.
//
// Takes the PC that Fetch drives every cycle and issues it to a
// synchronous-read instruction memory (1-cycle latency). The returned word is
// paired with its PC in a 2-entry FIFO and presented to decode with a
// valid/ready handshake. Fetch is back-pressured with fetch_stall, and a
// taken branch (flush) discards everything in flight or buffered.
//
// Issue rule is credit based: a read is only issued when the FIFO is
// guaranteed to have a free slot for its data the following cycle, so the
// returning word never has to be dropped or held.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   addr     [31:0] in  PC from Fetch, valid every cycle
//   flush          in   taken branch this cycle, kill in-flight/buffered work
//   imem_addr[31:0] out instruction memory address (= addr)
//   imem_en        out  memory read enable (request accepted this cycle)
//   imem_data[31:0] in  memory read data, valid the cycle after imem_en
//   fetch_stall    out  Fetch must hold addr across the next edge
//   id_valid       out  head entry valid
//   id_pc    [31:0] out PC of head entry
//   id_instr [31:0] out instruction of head entry
//   id_ready       in   decode accepts head this cycle
//   perf_stall_cnt [15:0] out  saturating stall-cycle count  (IFID_PERF_EN)
//   perf_flush_cnt [15:0] out  saturating flush count         (IFID_PERF_EN)
//
// Build option: define IFID_PERF_EN to add the two performance counters.
// Without it the counters and their ports do not exist.
// ---------------------------------------------------------------------------
module ifid_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        flush,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_data,
    output logic        fetch_stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    input  logic        id_ready
`ifdef IFID_PERF_EN
    ,
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    // Outstanding memory read.
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_pc_q,    req_pc_d;

    // 2-entry {pc, instr} FIFO.
    logic [31:0] fifo_pc_q    [2];
    logic [31:0] fifo_pc_d    [2];
    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_instr_d [2];
    logic [1:0]  count_q,  count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;

    logic        pop;
    logic        pop_eff;
    logic        push;
    logic        accept;
    logic [2:0]  occupancy;

    // Handshake and issue decision.
    always_comb begin
        id_valid  = (count_q != 2'd0);
        id_pc     = fifo_pc_q[rd_ptr_q];
        id_instr  = fifo_instr_q[rd_ptr_q];
        imem_addr = addr;

        pop       = id_valid & id_ready;
        // Entries already held plus the one whose data is still on its way.
        occupancy = {1'b0, count_q} + {2'b00, req_valid_q};
        // occupancy - pop < 2, rearranged so nothing can underflow.
        accept    = !flush && (occupancy < (3'd2 + {2'b00, pop}));

        imem_en     = accept;
        fetch_stall = !accept;

        // A flush cancels both the arriving word and any pop this cycle.
        push    = req_valid_q & !flush;
        pop_eff = pop & !flush;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        req_valid_d  = accept;
        req_pc_d     = accept ? addr : req_pc_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;

        if (push) begin
            fifo_pc_d[wr_ptr_q]    = req_pc_q;
            fifo_instr_d[wr_ptr_q] = imem_data;
            wr_ptr_d               = ~wr_ptr_q;
        end
        if (pop_eff) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({push, pop_eff})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_valid_q  <= 1'b0;
            req_pc_q     <= '0;
            // NOTE: the FIFO storage is reset because the head is visible on
            // id_pc/id_instr and must read as zero out of reset.
            fifo_pc_q    <= '{default: '0};
            fifo_instr_q <= '{default: '0};
            count_q      <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
        end else begin
            req_valid_q  <= req_valid_d;
            req_pc_q     <= req_pc_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

`ifdef IFID_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters; a flush cycle is counted as a flush, not a stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (fetch_stall && !flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_stage.sv
// ---------------------------------------------------------------------------
// tb_ifid_stage -- scoreboard bench for ifid_stage.
//
// A small Fetch model advances the PC whenever the stage does not stall and
// jumps to a target on flush. The stimulus process pushes the hand-derived
// list of {pc, instr} pairs that decode must receive into a queue; a separate
// monitor pops and compares on every handshake. Per-cycle fetch_stall and
// id_valid expectations are checked directly by the stimulus process.
// Memory model: instr = addr ^ 32'hA5A5_0000, 1-cycle synchronous read.
// ---------------------------------------------------------------------------
module tb_ifid_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_data;
    logic        fetch_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;
`ifdef IFID_PERF_EN
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    int          n_cmp = 0;
    int          n_mis = 0;
    ent_t        sb [$];
    logic [31:0] pc;

    ifid_stage dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .flush       (flush),
        .imem_addr   (imem_addr),
        .imem_en     (imem_en),
        .imem_data   (imem_data),
        .fetch_stall (fetch_stall),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .id_ready    (id_ready)
`ifdef IFID_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    initial imem_data = '0;
    always @(posedge clk) begin
        if (imem_en) imem_data <= imem_addr ^ KEY;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_push(input logic [31:0] p);
        sb.push_back('{pc: p, instr: p ^ KEY});
    endtask

    // Monitor: every completed handshake must match the scoreboard head.
    always @(negedge clk) begin
        if (reset && id_valid && id_ready && !flush) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_delivery: got pc %h, expected nothing", id_pc);
            end else begin
                ent_t e;
                e = sb.pop_front();
                check("deliver_pc", id_pc, e.pc);
                check("deliver_instr", id_instr, e.instr);
            end
        end
    end

    // A push into a full FIFO would lose data; the credit rule must prevent it.
    always @(negedge clk) begin
        if (reset) begin
            assert (!(dut.req_valid_q && !flush && dut.count_q == 2'd2))
            else begin
                n_mis++;
                $display("FAIL push_at_full: push with count 2, expected none");
            end
        end
    end

    // One cycle: apply inputs, check mid-cycle, let the Fetch model react.
    // exp_stall / exp_valid of -1 mean "not checked this cycle".
    task automatic cycle(input logic fl, input logic rdy, input logic [31:0] tgt,
                         input int exp_stall, input int exp_valid);
        logic stall_seen;
        flush    = fl;
        id_ready = rdy;
        @(negedge clk);
        stall_seen = fetch_stall;
        check("imem_addr", imem_addr, addr);
        if (exp_stall >= 0) begin
            check("fetch_stall", {31'd0, fetch_stall}, exp_stall);
            check("imem_en", {31'd0, imem_en}, (exp_stall == 0) ? 32'd1 : 32'd0);
        end
        if (exp_valid >= 0) check("id_valid", {31'd0, id_valid}, exp_valid);
        @(posedge clk);
        #1;
        if (fl)               pc = tgt;
        else if (!stall_seen) pc = pc + 32'd4;
        addr = pc;
    endtask

    initial begin
        reset    = 1'b0;
        pc       = 32'h0;
        addr     = 32'h0;
        flush    = 1'b0;
        id_ready = 1'b1;

        // Reset values.
        #12;
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_imem_en", {31'd0, imem_en}, 32'd1);
        check("rst_fetch_stall", {31'd0, fetch_stall}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Delivered sequence for stream, back-pressure, flush, double flush.
        exp_push(32'h000); exp_push(32'h004); exp_push(32'h008); exp_push(32'h00C);
        exp_push(32'h100); exp_push(32'h104);
        exp_push(32'h300); exp_push(32'h304); exp_push(32'h308);

        // Stream: 0 reaches decode in cycle 2.
        cycle(1'b0, 1'b1, 32'h0, 0, 0);
        cycle(1'b0, 1'b1, 32'h0, 0, 0);
        cycle(1'b0, 1'b1, 32'h0, 0, 1);
        // Back-pressure from pc 4: buffer holds 4,8, Fetch held at 12.
        cycle(1'b0, 1'b0, 32'h0, 1, 1);
        cycle(1'b0, 1'b0, 32'h0, 1, 1);
        cycle(1'b0, 1'b0, 32'h0, 1, 1);
        check("held_addr", addr, 32'h00C);
        // Release: stall drops in the same cycle, 4,8,12 without gaps.
        cycle(1'b0, 1'b1, 32'h0, 0, 1);
        cycle(1'b0, 1'b1, 32'h0, 0, 1);
        cycle(1'b0, 1'b1, 32'h0, 0, 1);
        // Fill to count 2 (16,20), then flush to 0x100 with a pop requested.
        cycle(1'b0, 1'b0, 32'h0, 1, 1);
        cycle(1'b1, 1'b1, 32'h100, 1, 1);
        cycle(1'b0, 1'b1, 32'h0, 0, 0);
        cycle(1'b0, 1'b1, 32'h0, 0, 0);
        cycle(1'b0, 1'b1, 32'h0, 0, 1);   // F+3: target valid
        cycle(1'b0, 1'b1, 32'h0, 0, 1);
        // Back-to-back flushes: 0x200 is never issued, 0x300 stream follows.
        cycle(1'b1, 1'b1, 32'h200, 1, 1);
        cycle(1'b1, 1'b1, 32'h300, 1, 0);
        cycle(1'b0, 1'b1, 32'h0, 0, 0);
        cycle(1'b0, 1'b1, 32'h0, 0, 0);
        cycle(1'b0, 1'b1, 32'h0, 0, 1);
        cycle(1'b0, 1'b1, 32'h0, 0, 1);
        cycle(1'b0, 1'b1, 32'h0, 0, 1);
        // Park with decode not ready so the buffer fills again.
        cycle(1'b0, 1'b0, 32'h0, 1, 1);
        cycle(1'b0, 1'b0, 32'h0, 1, 1);
        check("sb_drained_1", sb.size(), 32'd0);

        // Async reset between edges with a non-empty buffer.
        check("valid_before_reset", {31'd0, id_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_id_valid", {31'd0, id_valid}, 32'd0);
        check("async_id_pc", id_pc, 32'd0);
        check("async_id_instr", id_instr, 32'd0);
        check("async_imem_en", {31'd0, imem_en}, 32'd1);
        check("async_fetch_stall", {31'd0, fetch_stall}, 32'd0);
        pc   = 32'h500;
        addr = pc;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_push(32'h500); exp_push(32'h504);
        cycle(1'b0, 1'b1, 32'h0, 0, 0);
        cycle(1'b0, 1'b1, 32'h0, 0, 0);
        cycle(1'b0, 1'b1, 32'h0, 0, 1);
        cycle(1'b0, 1'b1, 32'h0, 0, 1);
        cycle(1'b0, 1'b0, 32'h0, 1, 1);
        cycle(1'b0, 1'b0, 32'h0, 1, 1);
        check("sb_drained_2", sb.size(), 32'd0);

`ifdef IFID_PERF_EN
        reset = 1'b0;
        #2;
        check("perf_stall_rst", {16'd0, perf_stall_cnt}, 32'd0);
        check("perf_flush_rst", {16'd0, perf_flush_cnt}, 32'd0);
        pc   = 32'h600;
        addr = pc;
        @(posedge clk);
        #1;
        reset = 1'b1;
        // Two accepts, three stall cycles, then two flushes.
        cycle(1'b0, 1'b0, 32'h0, 0, 0);
        cycle(1'b0, 1'b0, 32'h0, 0, 0);
        cycle(1'b0, 1'b0, 32'h0, 1, 1);
        cycle(1'b0, 1'b0, 32'h0, 1, 1);
        cycle(1'b0, 1'b0, 32'h0, 1, 1);
        cycle(1'b1, 1'b0, 32'h700, 1, 1);
        cycle(1'b1, 1'b0, 32'h800, 1, 0);
        check("perf_stall_3", {16'd0, perf_stall_cnt}, 32'd3);
        check("perf_flush_2", {16'd0, perf_flush_cnt}, 32'd2);
        flush    = 1'b0;
        id_ready = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        check("perf_stall_sat", {16'd0, perf_stall_cnt}, 32'h0000FFFF);
        check("perf_flush_hold", {16'd0, perf_flush_cnt}, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
